// File: rtl/b_calc_pkg.sv
// Shared definitions for the 8-bit calculator: ALU operator keycodes,
// keypad control codes, the entry sequencer state type and the
// sign-magnitude operand helper.
package b_calc_pkg;

  // ALU operator keycodes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_INV  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SHR  = 4'b1000;
  localparam logic [3:0] ALU_SHL  = 4'b1001;
  localparam logic [3:0] ALU_ASHR = 4'b1010;
  localparam logic [3:0] ALU_ASHL = 4'b1011;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  // Keypad control codes (digits are 0_dddd, operators 1_oooo)
  localparam logic [4:0] KEY_SIGN = 5'b1_1100;
  localparam logic [4:0] KEY_BKSP = 5'b1_1101;
  localparam logic [4:0] KEY_CLR  = 5'b1_1110;
  localparam logic [4:0] KEY_EQ   = 5'b1_1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_RESULT
  } b_inp_state_t;

  // Sign-magnitude operand; a negative zero is folded to plain zero.
  function automatic logic [8:0] b_inp_compose(input logic sign, input logic [7:0] mag);
    return {sign & (mag != 8'd0), mag};
  endfunction

endpackage

// File: rtl/b_inp_digit_acc.sv
// Decimal digit accumulator: holds the entry magnitude and the
// digit-pending flag, evaluates mag*10+d against the 8-bit limit and,
// when B_INP_BACKSPACE_EN is defined, provides the /10 backspace path.
module b_inp_digit_acc
  import b_calc_pkg::*;
(
  input  logic       i_sys_clock,
  input  logic       i_sys_reset,
  input  logic       digit_valid,
  input  logic       digit_load,
  input  logic       entry_clear,
`ifdef B_INP_BACKSPACE_EN
  input  logic       bksp,
  output logic       bksp_empty,
`endif
  input  logic [3:0] digit,
  output logic       digit_fits,
  output logic [7:0] mag_next,
  output logic       pending
);

  logic [7:0]  mag_reg;
  logic        pending_reg;
  logic        pending_next;
  logic [11:0] prod;

  // mag*10 built from shifts; 12 bits covers 255*10+9
  assign prod       = ({4'd0, mag_reg} << 3) + ({4'd0, mag_reg} << 1) + {8'd0, digit};
  assign digit_fits = (prod <= 12'd255);
  assign pending    = pending_reg;

`ifdef B_INP_BACKSPACE_EN
  logic [7:0] mag_quot;
  assign mag_quot   = mag_reg / 8'd10;
  // Leading zeros carry no value, so a zero quotient leaves nothing pending
  assign bksp_empty = (mag_quot == 8'd0);
`endif

  // Next magnitude: clear wins, then fresh load, then accumulate, then backspace
  always_comb begin
    mag_next     = mag_reg;
    pending_next = pending_reg;
    if (entry_clear) begin
      mag_next     = 8'd0;
      pending_next = 1'b0;
    end else if (digit_load) begin
      mag_next     = {4'd0, digit};
      pending_next = 1'b1;
    end else if (digit_valid && digit_fits) begin
      mag_next     = prod[7:0];
      pending_next = 1'b1;
    end
`ifdef B_INP_BACKSPACE_EN
    else if (bksp) begin
      mag_next     = mag_quot;
      pending_next = !bksp_empty;
    end
`endif
  end

  // Magnitude and pending-flag registers
  always_ff @(posedge i_sys_clock) begin
    if (i_sys_reset) begin
      mag_reg     <= 8'd0;
      pending_reg <= 1'b0;
    end else begin
      mag_reg     <= mag_next;
      pending_reg <= pending_next;
    end
  end

endmodule

// File: rtl/b_input_ctrl.sv
// Keypad-to-ALU entry sequencer. Builds the sign-magnitude operand from
// digit keys and drives the ALU keycode/enable/equal handshake so the ALU
// computes once per key with its previously latched operator.
// Optional feature macro: B_INP_BACKSPACE_EN (backspace key support).
module b_input_ctrl
  import b_calc_pkg::*;
#(
  parameter int P_STROBE_LEN = 2
)
(
  input  logic       i_sys_clock,
  input  logic       i_sys_reset,
  input  logic       i_b_inp_key_valid,
  input  logic [4:0] i_b_inp_key_code,
  output logic [8:0] o_b_inp_operand,
  output logic [3:0] o_b_inp_op_keycode,
  output logic       o_b_inp_en,
  output logic       o_b_inp_equal,
  output logic       o_b_inp_alu_clear,
  output logic       o_b_inp_entry_active,
  output logic       o_b_inp_entry_err,
  output logic       o_b_inp_busy
);

  localparam int              CNT_W    = (P_STROBE_LEN > 1) ? $clog2(P_STROBE_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_STROBE_LEN - 1);

  b_inp_state_t     state_reg, state_next;
  logic             sign_reg, sign_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       pend_keycode_reg, pend_keycode_next;
  logic             pend_equal_reg, pend_equal_next;
  logic             pend_result_reg, pend_result_next;
  logic [8:0]       operand_reg, operand_next;
  logic [3:0]       keycode_reg, keycode_next;
  logic             en_reg, en_next;
  logic             equal_reg, equal_next;
  logic             alu_clear_reg, alu_clear_next;
  logic             err_reg, err_next;
  logic             busy_reg, busy_next;

  logic             acc_digit_valid, acc_load, acc_clear, acc_fits, acc_pending;
  logic [7:0]       acc_mag_next;
`ifdef B_INP_BACKSPACE_EN
  logic             acc_bksp, acc_bksp_empty;
`endif

  logic key_digit, key_op;
  assign key_digit = !i_b_inp_key_code[4] && (i_b_inp_key_code[3:0] <= 4'd9);
  assign key_op    = i_b_inp_key_code[4] && (i_b_inp_key_code[3:2] != 2'b11);

  b_inp_digit_acc u_acc (
    .i_sys_clock (i_sys_clock),
    .i_sys_reset (i_sys_reset),
    .digit_valid (acc_digit_valid),
    .digit_load  (acc_load),
    .entry_clear (acc_clear),
`ifdef B_INP_BACKSPACE_EN
    .bksp        (acc_bksp),
    .bksp_empty  (acc_bksp_empty),
`endif
    .digit       (i_b_inp_key_code[3:0]),
    .digit_fits  (acc_fits),
    .mag_next    (acc_mag_next),
    .pending     (acc_pending)
  );

  // Next-state and next-output decode; keys only act in IDLE/ENTRY/RESULT
  always_comb begin
    state_next        = state_reg;
    sign_next         = sign_reg;
    cnt_next          = cnt_reg;
    pend_keycode_next = pend_keycode_reg;
    pend_equal_next   = pend_equal_reg;
    pend_result_next  = pend_result_reg;
    keycode_next      = keycode_reg;
    alu_clear_next    = 1'b0;
    err_next          = 1'b0;
    acc_digit_valid   = 1'b0;
    acc_load          = 1'b0;
    acc_clear         = 1'b0;
`ifdef B_INP_BACKSPACE_EN
    acc_bksp          = 1'b0;
`endif
    case (state_reg)
      ST_IDLE, ST_ENTRY, ST_RESULT: begin
        if (i_b_inp_key_valid) begin
          if (key_digit) begin
            if (state_reg == ST_RESULT) begin
              // New calculation: reset the ALU and start over with this digit
              alu_clear_next = 1'b1;
              acc_load       = 1'b1;
              sign_next      = 1'b0;
              state_next     = ST_ENTRY;
            end else if (acc_fits) begin
              acc_digit_valid = 1'b1;
              state_next      = ST_ENTRY;
            end else begin
              err_next = 1'b1;
            end
          end else if (i_b_inp_key_code == KEY_SIGN) begin
            if (state_reg == ST_RESULT) begin
              sign_next  = 1'b1;
              state_next = ST_IDLE;
            end else begin
              sign_next = ~sign_reg;
            end
          end else if (i_b_inp_key_code == KEY_CLR) begin
            alu_clear_next = 1'b1;
            acc_clear      = 1'b1;
            sign_next      = 1'b0;
            keycode_next   = ALU_NONE;
            state_next     = ST_IDLE;
          end else if (i_b_inp_key_code == KEY_EQ) begin
            if (state_reg == ST_ENTRY) begin
              pend_keycode_next = ALU_NONE;
              pend_equal_next   = 1'b1;
              pend_result_next  = 1'b1;
              state_next        = ST_SETUP;
            end
          end else if (key_op) begin
            if (i_b_inp_key_code[3:0] == ALU_INV) begin
              // Invert of the entry issues with en; invert of the result uses equal
              pend_keycode_next = ALU_INV;
              pend_equal_next   = (state_reg != ST_ENTRY);
              pend_result_next  = (state_reg != ST_ENTRY);
              state_next        = ST_SETUP;
            end else if (state_reg == ST_ENTRY) begin
              pend_keycode_next = i_b_inp_key_code[3:0];
              pend_equal_next   = 1'b0;
              pend_result_next  = 1'b0;
              state_next        = ST_SETUP;
            end else begin
              keycode_next = i_b_inp_key_code[3:0];
              state_next   = ST_IDLE;
            end
          end
`ifdef B_INP_BACKSPACE_EN
          else if (i_b_inp_key_code == KEY_BKSP && state_reg == ST_ENTRY) begin
            acc_bksp = 1'b1;
            if (acc_bksp_empty) begin
              sign_next  = 1'b0;
              state_next = ST_IDLE;
            end
          end
`endif
        end
      end
      ST_SETUP: begin
        // New keycode goes out together with the strobe
        state_next   = ST_PULSE;
        cnt_next     = '0;
        keycode_next = pend_keycode_reg;
      end
      ST_PULSE: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_GAP;
          acc_clear  = 1'b1;
          sign_next  = 1'b0;
          if (pend_keycode_reg == ALU_INV) begin
            keycode_next = ALU_NONE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_next = pend_result_reg ? ST_RESULT : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next    = (state_next == ST_SETUP) || (state_next == ST_PULSE) || (state_next == ST_GAP);
    // Operand is frozen for the whole issue sequence, even after the entry clears
    operand_next = busy_next ? operand_reg : b_inp_compose(sign_next, acc_mag_next);
    en_next      = (state_next == ST_PULSE) && !pend_equal_next;
    equal_next   = (state_next == ST_PULSE) && pend_equal_next;
  end

  // State and registered outputs
  always_ff @(posedge i_sys_clock) begin
    if (i_sys_reset) begin
      state_reg        <= ST_IDLE;
      sign_reg         <= 1'b0;
      cnt_reg          <= '0;
      pend_keycode_reg <= ALU_NONE;
      pend_equal_reg   <= 1'b0;
      pend_result_reg  <= 1'b0;
      operand_reg      <= 9'd0;
      keycode_reg      <= ALU_NONE;
      en_reg           <= 1'b0;
      equal_reg        <= 1'b0;
      alu_clear_reg    <= 1'b0;
      err_reg          <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sign_reg         <= sign_next;
      cnt_reg          <= cnt_next;
      pend_keycode_reg <= pend_keycode_next;
      pend_equal_reg   <= pend_equal_next;
      pend_result_reg  <= pend_result_next;
      operand_reg      <= operand_next;
      keycode_reg      <= keycode_next;
      en_reg           <= en_next;
      equal_reg        <= equal_next;
      alu_clear_reg    <= alu_clear_next;
      err_reg          <= err_next;
      busy_reg         <= busy_next;
    end
  end

  assign o_b_inp_operand      = operand_reg;
  assign o_b_inp_op_keycode   = keycode_reg;
  assign o_b_inp_en           = en_reg;
  assign o_b_inp_equal        = equal_reg;
  assign o_b_inp_alu_clear    = alu_clear_reg;
  assign o_b_inp_entry_active = acc_pending;
  assign o_b_inp_entry_err    = err_reg;
  assign o_b_inp_busy         = busy_reg;

endmodule

// File: tb/tb_b_input_ctrl.sv
// Directed bench for b_input_ctrl: a vector table for entry/clear behaviour
// and hand sequences for the multi-cycle issue, invert, busy-drop,
// mid-PULSE reset and backspace cases.
module tb_b_input_ctrl;
  import b_calc_pkg::*;

  localparam logic [4:0] K_ADD = 5'b10000;
  localparam logic [4:0] K_SUB = 5'b10001;
  localparam logic [4:0] K_MUL = 5'b10010;
  localparam logic [4:0] K_INV = 5'b10100;

  logic       clk = 1'b0;
  logic       srst;
  logic       key_valid;
  logic [4:0] key_code;
  logic [8:0] operand;
  logic [3:0] keycode;
  logic       en, equal, alu_clear, active, err, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  b_input_ctrl #(.P_STROBE_LEN(2)) dut (
    .i_sys_clock          (clk),
    .i_sys_reset          (srst),
    .i_b_inp_key_valid    (key_valid),
    .i_b_inp_key_code     (key_code),
    .o_b_inp_operand      (operand),
    .o_b_inp_op_keycode   (keycode),
    .o_b_inp_en           (en),
    .o_b_inp_equal        (equal),
    .o_b_inp_alu_clear    (alu_clear),
    .o_b_inp_entry_active (active),
    .o_b_inp_entry_err    (err),
    .o_b_inp_busy         (busy)
  );

  typedef struct {
    logic [4:0] code;
    logic [8:0] op;
    logic [3:0] kc;
    logic       clr;
    logic       act;
    logic       err;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  function automatic logic [18:0] mk(input logic [8:0] op, input logic [3:0] kc, input logic e,
                                     input logic q, input logic c, input logic a,
                                     input logic r, input logic b);
    return {op, kc, e, q, c, a, r, b};
  endfunction

  task automatic chk(input string name, input logic [18:0] want);
    logic [18:0] got;
    got = {operand, keycode, en, equal, alu_clear, active, err, busy};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got op=%h kc=%h en=%b eq=%b clr=%b act=%b err=%b busy=%b, want op=%h kc=%h en=%b eq=%b clr=%b act=%b err=%b busy=%b",
               name, got[18:10], got[9:6], got[5], got[4], got[3], got[2], got[1], got[0],
               want[18:10], want[9:6], want[5], want[4], want[3], want[2], want[1], want[0]);
    end else begin
      $display("ok   %-12s op=%h kc=%h en=%b eq=%b busy=%b", name, got[18:10], got[9:6], got[5], got[4], got[0]);
    end
  endtask

  // Drive one key for one cycle; returns at the following falling edge
  task automatic press(input logic [4:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 5'd0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    //          code      operand  kc     clr   act   err
    tbl[0]  = '{5'd1,     9'd1,    4'hF, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{5'd2,     9'd12,   4'hF, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{5'd3,     9'd123,  4'hF, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{5'd4,     9'd123,  4'hF, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{KEY_CLR,  9'd0,    4'hF, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{5'd5,     9'd5,    4'hF, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{KEY_SIGN, 9'h105,  4'hF, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{KEY_SIGN, 9'd5,    4'hF, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{5'd0,     9'd50,   4'hF, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{5'd0,     9'd50,   4'hF, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{KEY_CLR,  9'd0,    4'hF, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{KEY_SIGN, 9'd0,    4'hF, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{5'd0,     9'd0,    4'hF, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{5'd7,     9'h107,  4'hF, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{KEY_CLR,  9'd0,    4'hF, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{5'b01010, 9'd0,    4'hF, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{5'd2,     9'd2,    4'hF, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{5'd5,     9'd25,   4'hF, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{5'd5,     9'd255,  4'hF, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{5'd0,     9'd255,  4'hF, 1'b0, 1'b1, 1'b1};
    tbl[20] = '{KEY_CLR,  9'd0,    4'hF, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{K_MUL,    9'd0,    4'h2, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{KEY_SIGN, 9'd0,    4'h2, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{KEY_CLR,  9'd0,    4'hF, 1'b1, 1'b0, 1'b0};
    tbl[24] = '{5'd3,     9'd3,    4'hF, 1'b0, 1'b1, 1'b0};

    srst      = 1'b1;
    key_valid = 1'b0;
    key_code  = 5'd0;
    repeat (3) @(negedge clk);
    chk("reset", mk(9'd0, 4'hF, 0, 0, 0, 0, 0, 0));
    srst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      press(tbl[i].code);
      chk($sformatf("tbl%0d", i), mk(tbl[i].op, tbl[i].kc, 1'b0, 1'b0, tbl[i].clr, tbl[i].act, tbl[i].err, 1'b0));
    end

    // Entry 35 then ADD; a key pressed during SETUP must be dropped
    press(5'd5);   chk("d5",        mk(9'd35, 4'hF, 0, 0, 0, 1, 0, 0));
    press(K_ADD);  chk("add_setup", mk(9'd35, 4'hF, 0, 0, 0, 1, 0, 1));
    press(5'd9);   chk("add_pulse1", mk(9'd35, 4'h0, 1, 0, 0, 1, 0, 1));
    step();        chk("add_pulse2", mk(9'd35, 4'h0, 1, 0, 0, 1, 0, 1));
    step();        chk("add_gap",   mk(9'd35, 4'h0, 0, 0, 0, 0, 0, 1));
    step();        chk("add_idle",  mk(9'd0,  4'h0, 0, 0, 0, 0, 0, 0));

    // 7 then EQ: equal strobe with keycode NONE, then RESULT
    press(5'd7);   chk("d7",        mk(9'd7, 4'h0, 0, 0, 0, 1, 0, 0));
    press(KEY_EQ); chk("eq_setup",  mk(9'd7, 4'h0, 0, 0, 0, 1, 0, 1));
    step();        chk("eq_pulse1", mk(9'd7, 4'hF, 0, 1, 0, 1, 0, 1));
    step();        chk("eq_pulse2", mk(9'd7, 4'hF, 0, 1, 0, 1, 0, 1));
    step();        chk("eq_gap",    mk(9'd7, 4'hF, 0, 0, 0, 0, 0, 1));
    step();        chk("eq_result", mk(9'd0, 4'hF, 0, 0, 0, 0, 0, 0));
    press(KEY_EQ); chk("eq_ignored", mk(9'd0, 4'hF, 0, 0, 0, 0, 0, 0));

    // Digit in RESULT starts a new calculation, then invert of the entry
    press(5'd9);   chk("res_d9",    mk(9'd9, 4'hF, 0, 0, 1, 1, 0, 0));
    step();        chk("clr_pulse", mk(9'd9, 4'hF, 0, 0, 0, 1, 0, 0));
    press(K_INV);  chk("inv_setup", mk(9'd9, 4'hF, 0, 0, 0, 1, 0, 1));
    step();        chk("inv_pulse1", mk(9'd9, 4'h4, 1, 0, 0, 1, 0, 1));
    step();        chk("inv_pulse2", mk(9'd9, 4'h4, 1, 0, 0, 1, 0, 1));
    step();        chk("inv_gap",   mk(9'd9, 4'hF, 0, 0, 0, 0, 0, 1));
    step();        chk("inv_idle",  mk(9'd0, 4'hF, 0, 0, 0, 0, 0, 0));

    // Invert with no digits pending uses the equal strobe and ends in RESULT
    press(K_INV);  chk("rinv_setup", mk(9'd0, 4'hF, 0, 0, 0, 0, 0, 1));
    step();        chk("rinv_pulse1", mk(9'd0, 4'h4, 0, 1, 0, 0, 0, 1));
    step();        chk("rinv_pulse2", mk(9'd0, 4'h4, 0, 1, 0, 0, 0, 1));
    step();        chk("rinv_gap",  mk(9'd0, 4'hF, 0, 0, 0, 0, 0, 1));
    step();        chk("rinv_done", mk(9'd0, 4'hF, 0, 0, 0, 0, 0, 0));

    // 3, SIGN, SUB: negative operand issued (digit in RESULT also clears ALU)
    press(5'd3);   chk("res_d3",    mk(9'd3,   4'hF, 0, 0, 1, 1, 0, 0));
    press(KEY_SIGN); chk("neg3",    mk(9'h103, 4'hF, 0, 0, 0, 1, 0, 0));
    press(K_SUB);  chk("sub_setup", mk(9'h103, 4'hF, 0, 0, 0, 1, 0, 1));
    step();        chk("sub_pulse1", mk(9'h103, 4'h1, 1, 0, 0, 1, 0, 1));
    step();        chk("sub_pulse2", mk(9'h103, 4'h1, 1, 0, 0, 1, 0, 1));
    step();        chk("sub_gap",   mk(9'h103, 4'h1, 0, 0, 0, 0, 0, 1));
    step();        chk("sub_idle",  mk(9'd0,   4'h1, 0, 0, 0, 0, 0, 0));

    // 0, SIGN, ADD: negative zero suppressed; reset hits mid-PULSE
    press(5'd0);   chk("d0",        mk(9'd0, 4'h1, 0, 0, 0, 1, 0, 0));
    press(KEY_SIGN); chk("negzero", mk(9'd0, 4'h1, 0, 0, 0, 1, 0, 0));
    press(K_ADD);  chk("add0_setup", mk(9'd0, 4'h1, 0, 0, 0, 1, 0, 1));
    step();        chk("add0_pulse", mk(9'd0, 4'h0, 1, 0, 0, 1, 0, 1));
    srst = 1'b1;
    step();        chk("mid_reset", mk(9'd0, 4'hF, 0, 0, 0, 0, 0, 0));
    srst = 1'b0;
    press(5'd2);   chk("post_rst_d2", mk(9'd2, 4'hF, 0, 0, 0, 1, 0, 0));
    press(5'd5);   chk("d25",       mk(9'd25, 4'hF, 0, 0, 0, 1, 0, 0));

`ifdef B_INP_BACKSPACE_EN
    press(KEY_BKSP); chk("bksp1",   mk(9'd2, 4'hF, 0, 0, 0, 1, 0, 0));
    press(KEY_BKSP); chk("bksp2",   mk(9'd0, 4'hF, 0, 0, 0, 0, 0, 0));
`else
    press(KEY_BKSP); chk("bksp1",   mk(9'd25, 4'hF, 0, 0, 0, 1, 0, 0));
    press(KEY_BKSP); chk("bksp2",   mk(9'd25, 4'hF, 0, 0, 0, 1, 0, 0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
